// File: rtl/pitch_pkg.sv
// rtl/pitch_pkg.sv - shared state encodings for the pitch-shift window scheduler
package pitch_pkg;

  localparam int NUM_WINDOWS = 2;

  typedef enum logic [1:0] {
    SLOT_FREE     = 2'd0,
    SLOT_FILLING  = 2'd1,
    SLOT_FULL     = 2'd2,
    SLOT_DRAINING = 2'd3
  } slot_state_t;

  typedef enum logic [1:0] {
    IBUF_EMPTY   = 2'd0,
    IBUF_FULL    = 2'd1,
    IBUF_READING = 2'd2
  } ibuf_state_t;

  typedef enum logic {
    STAGE_IDLE = 1'b0,
    STAGE_BUSY = 1'b1
  } stage_state_t;

endpackage

// File: rtl/stage_tracker.sv
// rtl/stage_tracker.sv - per-stage done edge detect, IDLE/BUSY flag and registered go pulse
module stage_tracker
  import pitch_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic done,
  input  logic start_req,
  output logic done_evt,
  output logic avail,
  output logic go
);

  stage_state_t state_q, state_d;
  logic         hist_q, hist_d;
  logic         go_q, go_d;

  always_comb begin
    done_evt = done && !hist_q && (state_q == STAGE_BUSY);
    // avail reflects the state after this cycle's done edge, so a stage can restart immediately
    avail    = (state_q == STAGE_IDLE) || done_evt;
    hist_d   = done;
    go_d     = start_req;
    state_d  = state_q;
    if (done_evt)  state_d = STAGE_IDLE;
    if (start_req) state_d = STAGE_BUSY;
  end

  // History resets high so a done level held through reset release is not an edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= STAGE_IDLE;
      hist_q  <= 1'b1;
      go_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      go_q    <= go_d;
    end
  end

  assign go = go_q;

endmodule

// File: rtl/window_sched.sv
// rtl/window_sched.sv - ping-pong window scheduler; frame/drop counters built only with WINDOW_SCHED_STATS_EN
module window_sched
  import pitch_pkg::*;
#(
  parameter int FRAME_CNT_W = 16,
  parameter int DROP_CNT_W  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_ready,
  input  logic                   scaler_done,
  input  logic                   p2c_done,
  input  logic                   ifft_done,
  output logic                   scaler_go,
  output logic                   scaler_window,
  output logic                   p2c_go,
  output logic                   p2c_window,
  output logic                   ifft_go,
  output logic                   overrun,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic [DROP_CNT_W-1:0]  drop_count
);

  slot_state_t slot_q [NUM_WINDOWS];
  slot_state_t slot_d [NUM_WINDOWS];
  ibuf_state_t ibuf_q, ibuf_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic        scaler_window_q, scaler_window_d;
  logic        p2c_window_q, p2c_window_d;
  logic        overrun_q, overrun_d;

  logic sc_evt, sc_avail, sc_start;
  logic p2c_evt, p2c_avail, p2c_start;
  logic ifft_evt, ifft_avail, ifft_start;

  stage_tracker u_scaler (
    .clk       (clk),
    .reset     (reset),
    .done      (scaler_done),
    .start_req (sc_start),
    .done_evt  (sc_evt),
    .avail     (sc_avail),
    .go        (scaler_go)
  );

  stage_tracker u_p2c (
    .clk       (clk),
    .reset     (reset),
    .done      (p2c_done),
    .start_req (p2c_start),
    .done_evt  (p2c_evt),
    .avail     (p2c_avail),
    .go        (p2c_go)
  );

  stage_tracker u_ifft (
    .clk       (clk),
    .reset     (reset),
    .done      (ifft_done),
    .start_req (ifft_start),
    .done_evt  (ifft_evt),
    .avail     (ifft_avail),
    .go        (ifft_go)
  );

  always_comb begin
    slot_d          = slot_q;
    ibuf_d          = ibuf_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    scaler_window_d = scaler_window_q;
    p2c_window_d    = p2c_window_q;

    // Done edges first; start conditions below see the freed slots and stages
    if (ifft_evt) ibuf_d = IBUF_EMPTY;
    if (sc_evt) begin
      slot_d[wr_ptr_q] = SLOT_FULL;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (p2c_evt) begin
      slot_d[rd_ptr_q] = SLOT_FREE;
      rd_ptr_d         = ~rd_ptr_q;
      ibuf_d           = IBUF_FULL;
    end

    sc_start   = frame_ready && sc_avail && (slot_d[wr_ptr_d] == SLOT_FREE);
    p2c_start  = p2c_avail && (slot_d[rd_ptr_d] == SLOT_FULL) && (ibuf_d == IBUF_EMPTY);
    ifft_start = ifft_avail && (ibuf_d == IBUF_FULL);
    overrun_d  = frame_ready && !sc_start;

    if (sc_start) begin
      slot_d[wr_ptr_d] = SLOT_FILLING;
      scaler_window_d  = wr_ptr_d;
    end
    if (p2c_start) begin
      slot_d[rd_ptr_d] = SLOT_DRAINING;
      p2c_window_d     = rd_ptr_d;
    end
    if (ifft_start) ibuf_d = IBUF_READING;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_WINDOWS; i++) slot_q[i] <= SLOT_FREE;
      ibuf_q          <= IBUF_EMPTY;
      wr_ptr_q        <= 1'b0;
      rd_ptr_q        <= 1'b0;
      scaler_window_q <= 1'b0;
      p2c_window_q    <= 1'b0;
      overrun_q       <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_WINDOWS; i++) slot_q[i] <= slot_d[i];
      ibuf_q          <= ibuf_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      scaler_window_q <= scaler_window_d;
      p2c_window_q    <= p2c_window_d;
      overrun_q       <= overrun_d;
    end
  end

  assign scaler_window = scaler_window_q;
  assign p2c_window    = p2c_window_q;
  assign overrun       = overrun_q;

`ifdef WINDOW_SCHED_STATS_EN
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [DROP_CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

  // Frame count wraps; drop count sticks at all-ones
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    if (sc_start) frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
    if (overrun_d && (drop_cnt_q != {DROP_CNT_W{1'b1}})) drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign frame_count = frame_cnt_q;
  assign drop_count  = drop_cnt_q;
`else
  assign frame_count = '0;
  assign drop_count  = '0;
`endif

endmodule

// File: tb/tb_window_sched.sv
// tb/tb_window_sched.sv - directed scoreboard bench for window_sched
module tb_window_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_ready, scaler_done, p2c_done, ifft_done;
  logic        scaler_go, scaler_window, p2c_go, p2c_window, ifft_go, overrun;
  logic [15:0] frame_count;
  logic [7:0]  drop_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int   cyc;
    logic win;
  } ev_t;

  ev_t q_sc[$];
  ev_t q_p2c[$];
  ev_t q_ifft[$];
  ev_t q_ov[$];

  window_sched #(.FRAME_CNT_W(16), .DROP_CNT_W(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .frame_ready   (frame_ready),
    .scaler_done   (scaler_done),
    .p2c_done      (p2c_done),
    .ifft_done     (ifft_done),
    .scaler_go     (scaler_go),
    .scaler_window (scaler_window),
    .p2c_go        (p2c_go),
    .p2c_window    (p2c_window),
    .ifft_go       (ifft_go),
    .overrun       (overrun),
    .frame_count   (frame_count),
    .drop_count    (drop_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int exp_cnt(input int n);
`ifdef WINDOW_SCHED_STATS_EN
    return n;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic chk_unexp(input string tag, input int qsize);
    total++;
    assert (qsize != 0) else begin
      bad++;
      $error("FAIL %s got=pulse exp=none cyc=%0d", tag, cyc);
    end
  endtask

  // Expected events land one cycle after the negedge at which stimulus is driven
  task automatic exp_sc(input logic w);   q_sc.push_back('{cyc + 1, w});   endtask
  task automatic exp_p2c(input logic w);  q_p2c.push_back('{cyc + 1, w});  endtask
  task automatic exp_ifft();              q_ifft.push_back('{cyc + 1, 1'b0}); endtask
  task automatic exp_ov();                q_ov.push_back('{cyc + 1, 1'b0}); endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_frame();
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (!reset) begin
      if (scaler_go) begin
        chk_unexp("scaler_go_unexpected", q_sc.size());
        if (q_sc.size() != 0) begin
          e = q_sc.pop_front();
          chk("scaler_go_cycle", cyc, e.cyc);
          chk("scaler_window", int'(scaler_window), int'(e.win));
        end
      end
      if (p2c_go) begin
        chk_unexp("p2c_go_unexpected", q_p2c.size());
        if (q_p2c.size() != 0) begin
          e = q_p2c.pop_front();
          chk("p2c_go_cycle", cyc, e.cyc);
          chk("p2c_window", int'(p2c_window), int'(e.win));
        end
      end
      if (ifft_go) begin
        chk_unexp("ifft_go_unexpected", q_ifft.size());
        if (q_ifft.size() != 0) begin
          e = q_ifft.pop_front();
          chk("ifft_go_cycle", cyc, e.cyc);
        end
      end
      if (overrun) begin
        chk_unexp("overrun_unexpected", q_ov.size());
        if (q_ov.size() != 0) begin
          e = q_ov.pop_front();
          chk("overrun_cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    reset       = 1'b1;
    frame_ready = 1'b0;
    scaler_done = 1'b0;
    p2c_done    = 1'b0;
    ifft_done   = 1'b0;
    wait_cyc(3);
    chk("rst_gos", int'({scaler_go, p2c_go, ifft_go, overrun}), 0);
    chk("rst_windows", int'({scaler_window, p2c_window}), 0);
    chk("rst_frame_count", int'(frame_count), 0);
    chk("rst_drop_count", int'(drop_count), 0);
    reset = 1'b0;
    wait_cyc(5);

    // First frame accepted into window 0
    exp_sc(1'b0);
    pulse_frame();
    chk("frame_count_1", int'(frame_count), exp_cnt(1));
    wait_cyc(3);

    // Scaler busy: frame dropped
    exp_ov();
    pulse_frame();
    chk("drop_count_1", int'(drop_count), exp_cnt(1));
    chk("frame_count_still_1", int'(frame_count), exp_cnt(1));
    wait_cyc(8);

    scaler_done = 1'b1;
    exp_p2c(1'b0);
    wait_cyc(16);
    p2c_done = 1'b1;
    exp_ifft();
    wait_cyc(5);

    // ifft never finishes: fill slot 1, then slot 0, then drop
    exp_sc(1'b1);
    pulse_frame();
    scaler_done = 1'b0;
    p2c_done    = 1'b0;
    wait_cyc(4);
    scaler_done = 1'b1;
    wait_cyc(4);
    exp_sc(1'b0);
    pulse_frame();
    scaler_done = 1'b0;
    wait_cyc(4);
    scaler_done = 1'b1;
    wait_cyc(4);
    exp_ov();
    pulse_frame();
    chk("frame_count_3", int'(frame_count), exp_cnt(3));
    chk("drop_count_2", int'(drop_count), exp_cnt(2));
    chk("scaler_window_held", int'(scaler_window), 0);
    chk("p2c_window_held", int'(p2c_window), 0);
    wait_cyc(10);

    // Reset with scaler_done held high across release
    reset = 1'b1;
    wait_cyc(2);
    chk("rst2_gos", int'({scaler_go, p2c_go, ifft_go, overrun}), 0);
    reset = 1'b0;
    wait_cyc(4);
    chk("rst2_frame_count", int'(frame_count), 0);
    chk("rst2_drop_count", int'(drop_count), 0);
    exp_sc(1'b0);
    pulse_frame();
    scaler_done = 1'b0;
    wait_cyc(4);

    // frame_ready coincident with scaler_done rising on window 0
    scaler_done = 1'b1;
    exp_sc(1'b1);
    exp_p2c(1'b0);
    pulse_frame();
    scaler_done = 1'b0;
    chk("frame_count_2", int'(frame_count), exp_cnt(2));
    wait_cyc(3);

    // Continuous drops saturate drop_count
    frame_ready = 1'b1;
    repeat (260) begin
      exp_ov();
      @(negedge clk);
    end
    frame_ready = 1'b0;
    chk("drop_count_sat", int'(drop_count), exp_cnt(255));
    chk("frame_count_after_sat", int'(frame_count), exp_cnt(2));
    chk("scaler_window_hold1", int'(scaler_window), 1);
    chk("p2c_window_hold0", int'(p2c_window), 0);
    wait_cyc(5);

    chk("missed_scaler_go", q_sc.size(), 0);
    chk("missed_p2c_go", q_p2c.size(), 0);
    chk("missed_ifft_go", q_ifft.size(), 0);
    chk("missed_overrun", q_ov.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
